// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared types and constants for the AXI4-Lite register slave
package axi4lite_pkg;

  localparam int DEFAULT_NUM_REGS = 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi4lite_if.sv
// rtl/axi4lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_regfile.sv
// rtl/axi4lite_regfile.sv - byte-strobed register array with combinational read port
module axi4lite_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (i_wr_strb[b]) r_regs[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

  assign o_rd_data = r_regs[i_rd_idx];
endmodule

// File: rtl/axi4lite_slave.sv
// rtl/axi4lite_slave.sv - AXI4-Lite register slave with independent write and read FSMs
module axi4lite_slave
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic      ACLK,
  input  logic      ARESETN,
  axi4lite_if.slave s_axi
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  w_state_e                r_wstate;
  logic                    r_awready, r_wready, r_bvalid;
  resp_e                   r_bresp;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;

  r_state_e                r_rstate;
  logic                    r_arready, r_rvalid;
  resp_e                   r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok, w_rd_ok;
  logic [ADDR_WIDTH-1:0]   w_eff_addr;
  logic [DATA_WIDTH-1:0]   w_eff_data, w_rd_data;
  logic [DATA_WIDTH/8-1:0] w_eff_strb;

  assign w_aw_hs = s_axi.AWVALID & r_awready;
  assign w_w_hs  = s_axi.WVALID & r_wready;
  assign w_ar_hs = s_axi.ARVALID & r_arready;

  // Whichever half arrived first comes from the holding registers, the other straight off the bus.
  assign w_eff_addr = (r_wstate == W_HAVE_ADDR) ? r_awaddr : s_axi.AWADDR;
  assign w_eff_data = (r_wstate == W_HAVE_DATA) ? r_wdata  : s_axi.WDATA;
  assign w_eff_strb = (r_wstate == W_HAVE_DATA) ? r_wstrb  : s_axi.WSTRB;
  assign w_wr_ok    = w_eff_addr < ADDR_LIMIT;
  assign w_rd_ok    = s_axi.ARADDR < ADDR_LIMIT;

  always_comb begin
    w_commit = 1'b0;
    case (r_wstate)
      W_IDLE:      w_commit = w_aw_hs & w_w_hs;
      W_HAVE_ADDR: w_commit = w_w_hs;
      W_HAVE_DATA: w_commit = w_aw_hs;
      default:     w_commit = 1'b0;
    endcase
  end

  axi4lite_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .i_clk    (ACLK),
    .i_resetn (ARESETN),
    .i_wr_en  (w_commit & w_wr_ok),
    .i_wr_idx (w_eff_addr[2 +: IDX_W]),
    .i_wr_data(w_eff_data),
    .i_wr_strb(w_eff_strb),
    .i_rd_idx (s_axi.ARADDR[2 +: IDX_W]),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_wstate  <= W_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wstate  <= W_HAVE_ADDR;
            r_awaddr  <= s_axi.AWADDR;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else if (w_w_hs) begin
            r_wstate  <= W_HAVE_DATA;
            r_wdata   <= s_axi.WDATA;
            r_wstrb   <= s_axi.WSTRB;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is sampled from the pre-edge array, so a same-edge write is not visible.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_ok ? w_rd_data : '0;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;
  assign s_axi.ARREADY = r_arready;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RRESP   = r_rresp;
  assign s_axi.RDATA   = r_rdata;
endmodule

// File: tb/tb_axi4lite_slave.sv
// tb/tb_axi4lite_slave.sv - self-checking bench for axi4lite_slave
module tb_axi4lite_slave;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK   (clk),
    .ARESETN(resetn),
    .s_axi  (bus)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int cyc;
    bit aw_done, w_done, aw_now, w_now;
    cyc = 0; aw_done = 0; w_done = 0;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      tick();
      cyc++;
      if (aw_now) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_now)  begin w_done = 1;  bus.WVALID = 1'b0; end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    if (!(aw_done && w_done)) begin
      check($sformatf("wr_%08h_handshake_timeout", addr), 32'd0, 32'd1);
      return;
    end
    check($sformatf("wr_%08h_bvalid", addr), 32'(bus.BVALID), 32'd1);
    check($sformatf("wr_%08h_bresp", addr), 32'(bus.BRESP), 32'(exp_resp));
    tick();
    check($sformatf("wr_%08h_bvalid_drop", addr), 32'(bus.BVALID), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    int cyc;
    cyc = 0;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    while (!bus.ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bus.ARREADY) begin
      bus.ARVALID = 1'b0;
      check($sformatf("rd_%08h_arready_timeout", addr), 32'd0, 32'd1);
      return;
    end
    tick();
    bus.ARVALID = 1'b0;
    check($sformatf("rd_%08h_rvalid", addr), 32'(bus.RVALID), 32'd1);
    check($sformatf("rd_%08h_rdata", addr), bus.RDATA, exp_data);
    check($sformatf("rd_%08h_rresp", addr), 32'(bus.RRESP), 32'(exp_resp));
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check($sformatf("rd_%08h_rvalid_drop", addr), 32'(bus.RVALID), 32'd0);
  endtask

  initial begin
    logic [31:0] reg_exp [8];

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    // Reset values and first READY assertion.
    repeat (3) tick();
    check("rst_awready", 32'(bus.AWREADY), 32'd0);
    check("rst_wready", 32'(bus.WREADY), 32'd0);
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_bvalid", 32'(bus.BVALID), 32'd0);
    check("rst_rvalid", 32'(bus.RVALID), 32'd0);
    check("rst_bresp", 32'(bus.BRESP), 32'd0);
    check("rst_rresp", 32'(bus.RRESP), 32'd0);
    check("rst_rdata", bus.RDATA, 32'd0);
    resetn = 1'b1;
    check("rel_awready_pre_edge", 32'(bus.AWREADY), 32'd0);
    tick();
    check("rel_awready", 32'(bus.AWREADY), 32'd1);
    check("rel_wready", 32'(bus.WREADY), 32'd1);
    check("rel_arready", 32'(bus.ARREADY), 32'd1);

    // W at cycle 0, AW at cycle 3.
    bus.WDATA = 32'h0000_00AA; bus.WSTRB = 4'h1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("wfirst_wready_c%0d", c), 32'(bus.WREADY), 32'd0);
      check($sformatf("wfirst_bvalid_c%0d", c), 32'(bus.BVALID), 32'd0);
      if (c == 3) begin bus.AWADDR = 32'h08; bus.AWVALID = 1'b1; end
      else tick();
    end
    tick();
    bus.AWVALID = 1'b0;
    check("wfirst_bvalid_c4", 32'(bus.BVALID), 32'd1);
    check("wfirst_bresp_c4", 32'(bus.BRESP), 32'd0);
    tick();
    check("wfirst_bvalid_drop", 32'(bus.BVALID), 32'd0);
    do_read(32'h08, 32'h0000_00AA, 2'b00);

    vecs.push_back('{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00});
    vecs.push_back('{1'b1, 32'h0C, 32'h1122_3344, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h6, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 32'h11FF_FF44, 2'b00});
    vecs.push_back('{1'b1, 32'h00, 32'hA5A5_0001, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h1C, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 2'b10});
    vecs.push_back('{1'b0, 32'h24, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b10});
    vecs.push_back('{1'b1, 32'h06, 32'h0BAD_F00D, 4'h3, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'hDEAD_F00D, 2'b00});
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    reg_exp = '{32'hA5A5_0001, 32'hDEAD_F00D, 32'h0000_00AA, 32'h11FF_FF44,
                32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    for (int r = 0; r < 8; r++) do_read(32'(r * 4), reg_exp[r], 2'b00);

    // Read and write of the same register on one edge, both responses stalled.
    bus.AWADDR = 32'h10; bus.WDATA = 32'h1357_9BDF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    bus.ARADDR = 32'h10; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    check("coll_ready_all", 32'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 32'h7);
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("coll_bvalid_%0d", c), 32'(bus.BVALID), 32'd1);
      check($sformatf("coll_bresp_%0d", c), 32'(bus.BRESP), 32'd0);
      check($sformatf("coll_rvalid_%0d", c), 32'(bus.RVALID), 32'd1);
      check($sformatf("coll_rdata_%0d", c), bus.RDATA, 32'h0);
      check($sformatf("coll_awready_%0d", c), 32'(bus.AWREADY), 32'd0);
      tick();
    end
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    check("coll_bvalid_drop", 32'(bus.BVALID), 32'd0);
    check("coll_rvalid_drop", 32'(bus.RVALID), 32'd0);
    do_read(32'h10, 32'h1357_9BDF, 2'b00);

    // Read of 0x00 with RREADY held low for five cycles.
    bus.ARADDR = 32'h00; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    tick();
    bus.ARVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_rvalid_%0d", c), 32'(bus.RVALID), 32'd1);
      check($sformatf("stall_rdata_%0d", c), bus.RDATA, 32'hA5A5_0001);
      check($sformatf("stall_arready_%0d", c), 32'(bus.ARREADY), 32'd0);
      tick();
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("stall_rvalid_drop", 32'(bus.RVALID), 32'd0);
    check("stall_arready_back", 32'(bus.ARREADY), 32'd1);

    // Reset while holding an address with no data yet.
    bus.AWADDR = 32'h04; bus.AWVALID = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    check("rstmid_awready_held", 32'(bus.AWREADY), 32'd0);
    check("rstmid_wready_open", 32'(bus.WREADY), 32'd1);
    resetn = 1'b0;
    bus.WDATA = 32'h5555_5555; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    check("rstmid_bvalid", 32'(bus.BVALID), 32'd0);
    check("rstmid_wready", 32'(bus.WREADY), 32'd0);
    resetn = 1'b1;
    tick();
    check("rstmid_awready_back", 32'(bus.AWREADY), 32'd1);
    check("rstmid_wready_back", 32'(bus.WREADY), 32'd1);
    check("rstmid_arready_back", 32'(bus.ARREADY), 32'd1);
    check("rstmid_bvalid_after", 32'(bus.BVALID), 32'd0);
    for (int r = 0; r < 8; r++) do_read(32'(r * 4), 32'h0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4lite_slave.md
AXI4LITE_SLAVE -- requirements
Module: axi4lite_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers; decoded byte range is 0 to NUM_REGS*4-1.
REQ-004 SHALL have ports:
- ACLK in 1: single clock, all logic on its rising edge.
- ARESETN in 1: reset, synchronous, active-low.
- AWADDR in ADDR_WIDTH, AWVALID in 1, AWREADY out 1: write address channel.
- WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, WVALID in 1, WREADY out 1: write data channel.
- BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
- ARADDR in ADDR_WIDTH, ARVALID in 1, ARREADY out 1: read address channel.
- RDATA out DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.

Function
REQ-005 SHALL complete a handshake on any channel in a cycle where VALID and READY are both high.
REQ-006 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
- W_IDLE: AWREADY=1, WREADY=1.
- AW and W handshakes in the same cycle go to W_RESP.
- AW handshake only goes to W_HAVE_ADDR (AWREADY=0, address held).
- W handshake only goes to W_HAVE_DATA (WREADY=0, data and strobe held).
REQ-007 W_HAVE_ADDR SHALL go to W_RESP on a W handshake; W_HAVE_DATA SHALL go to W_RESP on an AW handshake.
REQ-008 The register update SHALL occur at the clock edge that enters W_RESP.
- Register index is AWADDR[2+:$clog2(NUM_REGS)]; AWADDR[1:0] is ignored.
- Each byte lane i is written only where WSTRB[i]=1.
REQ-009 In W_RESP, BVALID SHALL be 1, AWREADY and WREADY SHALL be 0, and BRESP SHALL hold until the B handshake; the B handshake returns the FSM to W_IDLE.
REQ-010 BVALID SHALL assert exactly one cycle after the later of the AW and W handshakes.
REQ-011 If AWADDR >= NUM_REGS*4, BRESP SHALL be 2'b10 (SLVERR) and no register changes; otherwise BRESP SHALL be 2'b00 (OKAY).
REQ-012 Read FSM SHALL have states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
- An AR handshake moves R_IDLE to R_DATA.
- An R handshake moves R_DATA to R_IDLE.
REQ-013 RDATA and RRESP SHALL be captured at the AR handshake and held stable through R_DATA.
- RVALID asserts one cycle after the AR handshake.
- Back-to-back reads therefore take a minimum of 2 cycles each.
REQ-014 A read of ARADDR >= NUM_REGS*4 SHALL return RDATA=0 and RRESP=2'b10; an in-range read SHALL return RRESP=2'b00.
REQ-015 When an AR handshake coincides with the edge committing a write to the same register, RDATA SHALL return the pre-write value.
REQ-016 Read and write FSMs SHALL operate independently and concurrently.
REQ-017 Stalled BREADY or RREADY SHALL hold the respective FSM indefinitely without loss or change of response.

Reset
REQ-018 While ARESETN=0 at a rising ACLK:
- All registers SHALL clear to 0.
- Both FSMs SHALL return to idle, abandoning any partial or pending transaction without a register update.
REQ-019 Output values during and immediately after reset SHALL be:
- AWREADY=0, WREADY=0, ARREADY=0.
- BVALID=0, RVALID=0.
- BRESP=0, RRESP=0, RDATA=0.
REQ-020 READY outputs SHALL first assert in the cycle after the first edge with ARESETN=1.

Structure
REQ-021 Package axi4lite_pkg SHALL hold:
- the response enum (RESP_OKAY=2'b00, RESP_SLVERR=2'b10);
- the write-state and read-state enums;
- the default NUM_REGS constant.
REQ-022 Register storage SHALL be sub-module axi4lite_regfile:
- one byte-strobed write port;
- one combinational read port;
- synchronous active-low clear.

Verification
REQ-023 AW 0x04 and W 0xDEADBEEF/0xF in the same cycle, BREADY=1 -> BVALID next cycle with OKAY; a later read of 0x04 returns 0xDEADBEEF with OKAY.
REQ-024 W 0x000000AA/0x1 at cycle 0, AW 0x08 at cycle 3 -> WREADY=0 for cycles 1-3, BVALID at cycle 4; a read of 0x08 returns 0x000000AA.
REQ-025 Write 0x11223344 to 0x0C, then write 0xFFFFFFFF/WSTRB=0x6 to 0x0C -> a read of 0x0C returns 0x11FFFF44.
REQ-026 Write to 0x20 and read of 0x24 -> both return SLVERR, RDATA=0, and registers 0-7 are unchanged.
REQ-027 AR 0x00 with RREADY=0 for 5 cycles -> RVALID, RDATA and ARREADY=0 are held stable; the R handshake then occurs in the cycle RREADY rises.
REQ-028 ARESETN low for one cycle while in W_HAVE_ADDR -> all registers 0, no BVALID, READYs high again 1 cycle after reset release.
